// File: rtl/glb_ld_dma_if.sv
// glb_ld_dma_if: SRAM read-request / read-response bus between the load DMA
// and a GLB bank.
//   rdrq_rd_en          - read request valid (one cycle per line)
//   rdrq_rd_addr        - line-aligned byte address
//   rdrs_rd_data        - returned bank line
//   rdrs_rd_data_valid  - returned line valid (fixed latency after request)
// master = DMA side, slave = bank side.
interface glb_ld_dma_if #(
    parameter int GLB_ADDR_WIDTH  = 22,
    parameter int BANK_DATA_WIDTH = 64
);
    logic                       rdrq_rd_en;
    logic [GLB_ADDR_WIDTH-1:0]  rdrq_rd_addr;
    logic [BANK_DATA_WIDTH-1:0] rdrs_rd_data;
    logic                       rdrs_rd_data_valid;

    modport master (
        output rdrq_rd_en, rdrq_rd_addr,
        input  rdrs_rd_data, rdrs_rd_data_valid
    );

    modport slave (
        input  rdrq_rd_en, rdrq_rd_addr,
        output rdrs_rd_data, rdrs_rd_data_valid
    );
endinterface

// File: rtl/glb_ld_dma.sv
// glb_ld_dma: load-direction DMA of a GLB tile. Queues load headers, fetches
// bank lines one at a time and unpacks each line into CGRA words streamed to
// the fabric, with optional active/inactive duty-cycling and header repeat.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   hdr_*                - header push (wr_en, repeat/inactive flags, start
//                          byte address, word count, burst / idle lengths)
//   hdr_queue_full       - header queue cannot accept a push
//   start_pulse          - launch the next queued header (IDLE only)
//   rd_bus               - SRAM read request / response bus (master side)
//   stream_data_g2f/valid_g2f - streamed word to the fabric
//   done_pulse           - one-cycle pulse per completed header
module glb_ld_dma #(
    parameter int QUEUE_DEPTH         = 4,
    parameter int GLB_ADDR_WIDTH      = 22,
    parameter int BANK_DATA_WIDTH     = 64,
    parameter int CGRA_DATA_WIDTH     = 16,
    parameter int MAX_NUM_WORDS_WIDTH = 21,
    parameter int RD_LATENCY          = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hdr_wr_en,
    input  logic                           hdr_repeat_on,
    input  logic                           hdr_inactive_on,
    input  logic [GLB_ADDR_WIDTH-1:0]      hdr_start_addr,
    input  logic [MAX_NUM_WORDS_WIDTH-1:0] hdr_num_words,
    input  logic [MAX_NUM_WORDS_WIDTH-1:0] hdr_active_words,
    input  logic [MAX_NUM_WORDS_WIDTH-1:0] hdr_inactive_words,
    output logic                           hdr_queue_full,
    input  logic                           start_pulse,
    glb_ld_dma_if.master                   rd_bus,
    output logic [CGRA_DATA_WIDTH-1:0]     stream_data_g2f,
    output logic                           stream_valid_g2f,
    output logic                           done_pulse
);
    localparam int WPL   = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
    localparam int OFF_W = $clog2(WPL);
    localparam int LB_W  = $clog2(BANK_DATA_WIDTH / 8);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int AW    = GLB_ADDR_WIDTH;
    localparam int NW    = MAX_NUM_WORDS_WIDTH;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_INACTIVE = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    typedef struct packed {
        logic          repeat_on;
        logic          inactive_on;
        logic [AW-1:0] start_addr;
        logic [NW-1:0] num_words;
        logic [NW-1:0] active_words;
        logic [NW-1:0] inactive_words;
    } hdr_t;

    hdr_t                                 mem_q [QUEUE_DEPTH];
    hdr_t                                 cur_q, cur_d, new_hdr, head;
    logic [PTR_W-1:0]                     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_inc;
    logic [CNT_W-1:0]                     count_q, count_d;
    logic [2:0]                           state_q, state_d;
    logic [AW-1:0]                        addr_q, addr_d;
    logic [OFF_W-1:0]                     offset_q, offset_d, off_inc;
    logic [NW-1:0]                        remaining_q, remaining_d, rem_dec;
    logic [NW-1:0]                        burst_q, burst_d, burst_dec;
    logic [NW-1:0]                        idle_q, idle_d;
    logic [WPL-1:0][CGRA_DATA_WIDTH-1:0]  line_q, line_d;
    logic                                 push_re, push_new, pop, reserved;

    // Response timing is fixed by the bank, so WAIT simply watches valid.
    logic unused_ok;
    assign unused_ok = &{1'b0, RD_LATENCY > 0};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign new_hdr = '{hdr_repeat_on, hdr_inactive_on, hdr_start_addr,
                       hdr_num_words, hdr_active_words, hdr_inactive_words};
    assign head    = mem_q[rd_ptr_q];

    // A running repeat header keeps one slot reserved for its re-push.
    assign reserved       = (state_q != S_IDLE) && cur_q.repeat_on;
    assign hdr_queue_full = ({1'b0, count_q} + {{CNT_W{1'b0}}, reserved})
                            == (CNT_W + 1)'(QUEUE_DEPTH);

    assign push_re  = (state_q == S_DONE) && cur_q.repeat_on;
    assign push_new = hdr_wr_en && !hdr_queue_full;
    assign pop      = (state_q == S_IDLE) && start_pulse && (count_q != '0);
    assign wr_inc   = ptr_inc(wr_ptr_q);

    // Re-push lands first; a same-cycle external push takes the next slot.
    always_ff @(posedge clk) begin
        if (push_re)  mem_q[wr_ptr_q] <= cur_q;
        if (push_new) mem_q[push_re ? wr_inc : wr_ptr_q] <= new_hdr;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push_re)  wr_ptr_d = ptr_inc(wr_ptr_d);
        if (push_new) wr_ptr_d = ptr_inc(wr_ptr_d);
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_re) + CNT_W'(push_new) - CNT_W'(pop);
    end

    assign rem_dec   = remaining_q - 1'b1;
    assign off_inc   = offset_q + 1'b1;
    assign burst_dec = burst_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        addr_d      = addr_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        idle_d      = idle_q;
        line_d      = line_q;
        case (state_q)
            S_IDLE: if (pop) begin
                cur_d       = head;
                addr_d      = {head.start_addr[AW-1:LB_W], {LB_W{1'b0}}};
                offset_d    = head.start_addr[OFF_W:1];
                remaining_d = head.num_words;
                burst_d     = head.active_words;
                state_d     = (head.num_words == '0) ? S_DONE : S_REQ;
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (rd_bus.rdrs_rd_data_valid) begin
                line_d  = rd_bus.rdrs_rd_data;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                remaining_d = rem_dec;
                offset_d    = off_inc;
                if (cur_q.inactive_on) burst_d = burst_dec;
                if (rem_dec == '0) begin
                    state_d = S_DONE;
                end else if (cur_q.inactive_on && burst_dec == '0 &&
                             cur_q.inactive_words != '0) begin
                    idle_d  = cur_q.inactive_words;
                    state_d = S_INACTIVE;
                end else begin
                    // Burst ran out with no idle time: just start a new burst.
                    if (cur_q.inactive_on && burst_dec == '0) burst_d = cur_q.active_words;
                    if (off_inc == '0) begin
                        addr_d  = addr_q + AW'(8);
                        state_d = S_REQ;
                    end
                end
            end
            S_INACTIVE: begin
                idle_d = idle_q - 1'b1;
                if (idle_q == NW'(1)) begin
                    burst_d = cur_q.active_words;
                    // Line address only advances here if the burst ended on
                    // the last word of a line (INACTIVE beat the line fetch).
                    if (offset_q == '0) begin
                        addr_d  = addr_q + AW'(8);
                        state_d = S_REQ;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            addr_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            idle_q      <= '0;
            line_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            addr_q      <= addr_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            idle_q      <= idle_d;
            line_q      <= line_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    assign rd_bus.rdrq_rd_en   = (state_q == S_REQ);
    assign rd_bus.rdrq_rd_addr = addr_q;
    assign stream_valid_g2f    = (state_q == S_STREAM);
    assign stream_data_g2f     = stream_valid_g2f ? line_q[offset_q] : '0;
    assign done_pulse          = (state_q == S_DONE);
endmodule
